// File: rtl/sp_fifo_enq_serializer.sv
// Serializes one wide request into up to BEATS single-beat FIFO enqueues.
// Optional last-beat flag on enq_last_o when SP_FIFO_ENQ_SER_LAST_EN is defined.
module sp_fifo_enq_serializer #(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 8,
  localparam int unsigned LEN_W = $clog2(BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_vld_i,
  output logic                    req_rdy_o,
  input  logic [BEATS*BEAT_W-1:0] req_data_i,
  input  logic [LEN_W-1:0]        req_len_i,
  output logic                    enq_vld_o,
  output logic [BEAT_W-1:0]       enq_payload_o,
  input  logic                    enq_rdy_i,
  input  logic                    flush_i,
  output logic                    busy_o
`ifdef SP_FIFO_ENQ_SER_LAST_EN
  ,
  output logic                    enq_last_o
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BEATS*BEAT_W-1:0] r_data;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_idx;
  logic [LEN_W-1:0]        w_idx_nxt;
  logic [LEN_W-1:0]        w_len_eff;
  logic [LEN_W-1:0]        w_len_last;
  logic                    w_accept;
  logic                    w_fire;
  logic                    w_last_beat;
  logic [BEAT_W-1:0]       w_payload;

  // Oversized lengths saturate at the beat capacity.
  assign w_len_eff   = (req_len_i > LEN_W'(BEATS)) ? LEN_W'(BEATS) : req_len_i;
  assign req_rdy_o   = (r_state == S_IDLE) & ~flush_i;
  assign w_accept    = req_vld_i & req_rdy_o;
  assign enq_vld_o   = (r_state == S_SEND);
  assign busy_o      = (r_state == S_SEND);
  assign w_fire      = enq_vld_o & enq_rdy_i;
  assign w_len_last  = LEN_W'(r_len - LEN_W'(1));
  assign w_last_beat = (r_idx == w_len_last);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_idx_nxt = '0;
          if (w_len_eff != '0) w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else if (w_fire) begin
          if (w_last_beat) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = LEN_W'(r_idx + LEN_W'(1));
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) r_len <= w_len_eff;
    end
  end

  // Payload storage is don't-care until a request is accepted.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) r_data <= req_data_i;
  end

  always_comb begin
    w_payload = '0;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (r_idx == LEN_W'(k)) w_payload = r_data[k*BEAT_W +: BEAT_W];
    end
  end

  assign enq_payload_o = w_payload;

`ifdef SP_FIFO_ENQ_SER_LAST_EN
  assign enq_last_o = enq_vld_o & w_last_beat;
`else
  // No last-beat indication in this build.
`endif

endmodule

// File: tb/tb_sp_fifo_enq_serializer.sv
// Randomized bench for sp_fifo_enq_serializer against a queue-based beat model.
// Define SP_FIFO_ENQ_SER_LAST_EN to also check enq_last_o.
module tb_sp_fifo_enq_serializer;

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned W      = BEATS * BEAT_W;

  typedef logic [W-1:0] wide_t;

  logic              clk;
  logic              rst;
  logic              req_vld_i;
  logic              req_rdy_o;
  wide_t             req_data_i;
  logic [LEN_W-1:0]  req_len_i;
  logic              enq_vld_o;
  logic [BEAT_W-1:0] enq_payload_o;
  logic              enq_rdy_i;
  logic              flush_i;
  logic              busy_o;
  logic              enq_last_o;

  sp_fifo_enq_serializer #(.BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld_i     (req_vld_i),
    .req_rdy_o     (req_rdy_o),
    .req_data_i    (req_data_i),
    .req_len_i     (req_len_i),
    .enq_vld_o     (enq_vld_o),
    .enq_payload_o (enq_payload_o),
    .enq_rdy_i     (enq_rdy_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o)
`ifdef SP_FIFO_ENQ_SER_LAST_EN
    ,
    .enq_last_o    (enq_last_o)
`endif
  );

`ifndef SP_FIFO_ENQ_SER_LAST_EN
  assign enq_last_o = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_cmp;
  int                n_err;
  int                cyc;
  logic [BEAT_W-1:0] got_q[$];
  int                got_cyc[$];
  bit                got_last[$];
  int                acc_cyc[$];
  bit                rdy_hist[int];
  bit                vld_hist[int];
  bit                prev_hold;
  logic [BEAT_W-1:0] prev_pay;
  logic              s_vld;
  logic              s_busy;
  logic              s_rdy;
  logic [BEAT_W-1:0] s_pay;

  function automatic wide_t rand_wide();
    wide_t w;
    for (int k = 0; k < int'(BEATS); k++) w[k*BEAT_W +: BEAT_W] = {$urandom(), $urandom()};
    return w;
  endfunction

  function automatic logic [BEAT_W-1:0] beat_of(input wide_t w, input int k);
    return w[k*BEAT_W +: BEAT_W];
  endfunction

  function automatic int eff_len(input int len);
    return (len > int'(BEATS)) ? int'(BEATS) : len;
  endfunction

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    got_last.delete();
    acc_cyc.delete();
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, log fires/accepts, check handshake rules.
  task automatic tick(input logic vld, input wide_t data, input logic [LEN_W-1:0] len,
                      input logic rdy, input logic fl, input logic r);
    req_vld_i  = vld;
    req_data_i = data;
    req_len_i  = len;
    enq_rdy_i  = rdy;
    flush_i    = fl;
    rst        = r;
    #1;
    s_vld  = enq_vld_o;
    s_busy = busy_o;
    s_rdy  = req_rdy_o;
    s_pay  = enq_payload_o;
    n_cmp++;
    if (busy_o !== enq_vld_o) begin
      n_err++;
      $display("FAIL busy_eq_vld cyc=%0d: busy=%b vld=%b", cyc, busy_o, enq_vld_o);
    end
    if (prev_hold) begin
      n_cmp++;
      if (enq_vld_o !== 1'b1 || enq_payload_o !== prev_pay) begin
        n_err++;
        $display("FAIL hold_stable cyc=%0d: vld=%b pay=%h exp vld=1 pay=%h",
                 cyc, enq_vld_o, enq_payload_o, prev_pay);
      end
    end
    if (fl) begin
      n_cmp++;
      if (req_rdy_o !== 1'b0) begin
        n_err++;
        $display("FAIL rdy_during_flush cyc=%0d: got=%b exp=0", cyc, req_rdy_o);
      end
    end
    if (!r && enq_vld_o === 1'b1 && rdy) begin
      got_q.push_back(enq_payload_o);
      got_cyc.push_back(cyc);
      got_last.push_back(enq_last_o === 1'b1);
    end
    if (!r && vld && req_rdy_o === 1'b1) acc_cyc.push_back(cyc);
    rdy_hist[cyc] = (req_rdy_o === 1'b1);
    vld_hist[cyc] = (enq_vld_o === 1'b1);
    prev_hold = !r && !fl && (enq_vld_o === 1'b1) && !rdy;
    prev_pay  = enq_payload_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    tick(1'b0, '0, 4'd0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, '0, 4'd0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (enq_vld_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: vld=%b busy=%b exp 0/0", enq_vld_o, busy_o);
    end
    tick(1'b0, '0, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (s_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_req_rdy: got=%b exp=1", s_rdy);
    end
`ifdef SP_FIFO_ENQ_SER_LAST_EN
    n_cmp++;
    if (enq_last_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_last: got=%b exp=0", enq_last_o);
    end
`endif
  endtask

  task automatic test_basic();
    wide_t d;
    int    t;
    clear_log();
    d = rand_wide();
    d[0 +: BEAT_W]        = 64'hA0;
    d[BEAT_W +: BEAT_W]   = 64'hA1;
    d[2*BEAT_W +: BEAT_W] = 64'hA2;
    t = cyc;
    tick(1'b1, d, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (acc_cyc.size() != 1 || got_q.size() != 3) begin
      n_err++;
      $display("FAIL basic_counts: accepts=%0d beats=%0d exp 1/3", acc_cyc.size(), got_q.size());
    end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== beat_of(d, k) || got_cyc[k] != t + 1 + k) begin
        n_err++;
        $display("FAIL basic_beat%0d: pay=%h cyc=%0d exp pay=%h cyc=%0d",
                 k, got_q[k], got_cyc[k], beat_of(d, k), t + 1 + k);
      end
`ifdef SP_FIFO_ENQ_SER_LAST_EN
      n_cmp++;
      if (got_last[k] != (k == 2)) begin
        n_err++;
        $display("FAIL basic_last%0d: got=%b exp=%b", k, got_last[k], (k == 2));
      end
`endif
    end
    n_cmp++;
    if (rdy_hist[t+4] !== 1'b1 || vld_hist[t+4] !== 1'b0) begin
      n_err++;
      $display("FAIL basic_bubble: req_rdy=%b vld=%b exp 1/0", rdy_hist[t+4], vld_hist[t+4]);
    end
  endtask

  task automatic test_random();
    wide_t d;
    int    len;
    int    eff;
    int    bound;
    for (int n = 0; n < 24; n++) begin
      clear_log();
      d   = rand_wide();
      len = int'($urandom_range(0, 15));
      eff = eff_len(len);
      tick(1'b1, d, LEN_W'(len), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      bound = 0;
      while (got_q.size() < eff && bound < 200) begin
        tick(1'b0, d, 4'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        bound++;
      end
      tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (acc_cyc.size() != 1 || got_q.size() != eff) begin
        n_err++;
        $display("FAIL rand%0d_count len=%0d: accepts=%0d beats=%0d exp 1/%0d",
                 n, len, acc_cyc.size(), got_q.size(), eff);
      end
      for (int k = 0; k < eff && k < got_q.size(); k++) begin
        n_cmp++;
        if (got_q[k] !== beat_of(d, k)) begin
          n_err++;
          $display("FAIL rand%0d_beat%0d: got=%h exp=%h", n, k, got_q[k], beat_of(d, k));
        end
`ifdef SP_FIFO_ENQ_SER_LAST_EN
        n_cmp++;
        if (got_last[k] != (k == eff - 1)) begin
          n_err++;
          $display("FAIL rand%0d_last%0d: got=%b exp=%b", n, k, got_last[k], (k == eff - 1));
        end
`endif
      end
    end
  endtask

  task automatic test_backpressure();
    wide_t d;
    int    i;
    logic  rdy;
    clear_log();
    d = rand_wide();
    tick(1'b1, d, 4'd4, 1'b0, 1'b0, 1'b0);
    i = 0;
    while (got_q.size() < 4 && i < 40) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      tick(1'b0, d, 4'd0, rdy, 1'b0, 1'b0);
      if (!rdy) begin
        n_cmp++;
        if (s_vld !== 1'b1 || s_pay !== beat_of(d, got_q.size())) begin
          n_err++;
          $display("FAIL bp_stall%0d: vld=%b pay=%h exp vld=1 pay=%h",
                   i, s_vld, s_pay, beat_of(d, got_q.size()));
        end
      end
      i++;
    end
    tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL bp_count: got=%0d exp=4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== beat_of(d, k)) begin
        n_err++;
        $display("FAIL bp_beat%0d: got=%h exp=%h", k, got_q[k], beat_of(d, k));
      end
    end
  endtask

  task automatic test_len0_clamp();
    wide_t d;
    int    t;
    int    bound;
    clear_log();
    d = rand_wide();
    t = cyc;
    tick(1'b1, d, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (acc_cyc.size() != 1 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL len0_consume: accepts=%0d beats=%0d exp 1/0", acc_cyc.size(), got_q.size());
    end
    for (int i = 1; i <= 3; i++) begin
      n_cmp++;
      if (rdy_hist[t+i] !== 1'b1 || vld_hist[t+i] !== 1'b0) begin
        n_err++;
        $display("FAIL len0_idle%0d: req_rdy=%b vld=%b exp 1/0", i, rdy_hist[t+i], vld_hist[t+i]);
      end
    end
    clear_log();
    d = rand_wide();
    tick(1'b1, d, 4'd9, 1'b1, 1'b0, 1'b0);
    bound = 0;
    while (got_q.size() < 8 && bound < 40) begin
      tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
      bound++;
    end
    for (int i = 0; i < 3; i++) tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 8) begin
      n_err++;
      $display("FAIL clamp_count: got=%0d exp=8", got_q.size());
    end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== beat_of(d, k)) begin
        n_err++;
        $display("FAIL clamp_beat%0d: got=%h exp=%h", k, got_q[k], beat_of(d, k));
      end
    end
  endtask

  task automatic test_flush();
    wide_t d;
    wide_t d2;
    int    t;
    clear_log();
    d  = rand_wide();
    d2 = rand_wide();
    t  = cyc;
    tick(1'b1, d, 4'd8, 1'b1, 1'b0, 1'b0);
    tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, d, 4'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, d2, 4'd2, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (s_vld !== 1'b0 || acc_cyc.size() != 2 || acc_cyc[acc_cyc.size()-1] != t + 4) begin
      n_err++;
      $display("FAIL flush_reaccept: vld=%b accepts=%0d exp vld=0 accepts=2 at %0d",
               s_vld, acc_cyc.size(), t + 4);
    end
    for (int i = 0; i < 5; i++) tick(1'b0, d2, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL flush_count: got=%0d exp=4", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== beat_of(d, 0) || got_q[1] !== beat_of(d, 1) ||
          got_q[2] !== beat_of(d2, 0) || got_q[3] !== beat_of(d2, 1)) begin
        n_err++;
        $display("FAIL flush_beats: got=%h,%h,%h,%h exp=%h,%h,%h,%h",
                 got_q[0], got_q[1], got_q[2], got_q[3],
                 beat_of(d, 0), beat_of(d, 1), beat_of(d2, 0), beat_of(d2, 1));
      end
    end
    // Beat fired together with flush counts as delivered.
    clear_log();
    d = rand_wide();
    tick(1'b1, d, 4'd5, 1'b1, 1'b0, 1'b0);
    tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, d, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (s_vld !== 1'b0) begin
      n_err++;
      $display("FAIL flush_fire_vld: got=%b exp=0", s_vld);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 2 || got_q[got_q.size()-1] !== beat_of(d, 1)) begin
      n_err++;
      $display("FAIL flush_fire_count: got=%0d exp=2", got_q.size());
    end
    // Request offered during flush in IDLE must be refused.
    clear_log();
    tick(1'b1, d, 4'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (acc_cyc.size() != 0 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL flush_idle_refuse: accepts=%0d beats=%0d exp 0/0", acc_cyc.size(), got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    wide_t d;
    clear_log();
    d = rand_wide();
    tick(1'b1, d, 4'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, d, 4'd3, 1'b0, 1'b1, 1'b1);
    tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (s_vld !== 1'b0 || s_busy !== 1'b0 || s_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_outputs: vld=%b busy=%b rdy=%b exp 0/0/1", s_vld, s_busy, s_rdy);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, d, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL rstmid_count: got=%0d exp=4", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    wide_t a;
    wide_t b;
    a = rand_wide();
    b = rand_wide();
    clear_log();
    for (int i = 0; i < 20; i++)
      tick(acc_cyc.size() < 2, (acc_cyc.size() == 0) ? a : b, 4'd2, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 4 || acc_cyc.size() != 2) begin
      n_err++;
      $display("FAIL b2b_count: beats=%0d accepts=%0d exp 4/2", got_q.size(), acc_cyc.size());
    end else begin
      n_cmp++;
      if (got_cyc[1] - got_cyc[0] != 1 || got_cyc[2] - got_cyc[1] != 2 ||
          got_cyc[3] - got_cyc[2] != 1 || acc_cyc[1] != got_cyc[1] + 1) begin
        n_err++;
        $display("FAIL b2b_timing: fires=%0d,%0d,%0d,%0d accept2=%0d exp gaps 1,2,1 accept=last+1",
                 got_cyc[0], got_cyc[1], got_cyc[2], got_cyc[3], acc_cyc[1]);
      end
      n_cmp++;
      if (got_q[0] !== beat_of(a, 0) || got_q[1] !== beat_of(a, 1) ||
          got_q[2] !== beat_of(b, 0) || got_q[3] !== beat_of(b, 1)) begin
        n_err++;
        $display("FAIL b2b_beats: got=%h,%h,%h,%h", got_q[0], got_q[1], got_q[2], got_q[3]);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    cyc        = 0;
    prev_hold  = 1'b0;
    prev_pay   = '0;
    rst        = 1'b1;
    req_vld_i  = 1'b0;
    req_data_i = '0;
    req_len_i  = '0;
    enq_rdy_i  = 1'b0;
    flush_i    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_len0_clamp();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sp_fifo_enq_serializer.md
SP_FIFO_ENQ_SERIALIZER -- requirements
Module: sp_fifo_enq_serializer

Interface
REQ-001 SHALL have parameter BEAT_W, default 64: width of one FIFO payload beat.
REQ-002 SHALL have parameter BEATS, default 8: maximum beats per request.
REQ-003 SHALL have derived localparam LEN_W = $clog2(BEATS+1): request length field width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port req_vld_i  input  1: wide request valid.
REQ-007 SHALL have port req_rdy_o  output  1: wide request ready.
REQ-008 SHALL have port req_data_i  input  BEATS*BEAT_W: wide payload; beat k = bits [k*BEAT_W +: BEAT_W].
REQ-009 SHALL have port req_len_i  input  LEN_W: number of beats to send.
REQ-010 SHALL have port enq_vld_o  output  1: drives the FIFO enqueue valid.
REQ-011 SHALL have port enq_payload_o  output  BEAT_W: drives the FIFO enqueue payload.
REQ-012 SHALL have port enq_rdy_i  input  1: FIFO enqueue ready.
REQ-013 SHALL have port flush_i  input  1: abort the in-flight request.
REQ-014 SHALL have port busy_o  output  1: high while state is SEND.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and SEND; req_rdy_o = (state==IDLE) & ~flush_i.
REQ-016 SHALL accept a request on req_vld_i & req_rdy_o: capture req_data_i, an effective length, and reset the beat index to 0.
REQ-017 SHALL clamp the effective length to BEATS when req_len_i > BEATS.
REQ-018 SHALL consume a request with req_len_i == 0 and stay in IDLE, emitting no beats.
REQ-019 SHALL otherwise enter SEND on acceptance; enq_vld_o is asserted from the next cycle (1-cycle latency), never combinationally from req_vld_i.
REQ-020 SHALL drive enq_payload_o = captured beat[index], from a registered source, in ascending index order starting at 0.
REQ-021 SHALL hold enq_vld_o high and enq_payload_o stable while enq_rdy_i is low (no valid withdrawal without fire or flush).
REQ-022 SHALL increment the index on each fire (enq_vld_o & enq_rdy_i), at most one beat per cycle.
REQ-023 SHALL return to IDLE on the cycle after the fire of beat len-1; enq_vld_o is low and req_rdy_o high that cycle (one bubble between requests).
REQ-024 SHALL, on flush_i in any state, go to IDLE next cycle with enq_vld_o low and the remaining beats discarded; a beat fired in the flush cycle still counts as delivered.
REQ-025 SHALL never accept a request in a cycle with flush_i high.
REQ-026 SHALL make busy_o equal to (state==SEND), asserting exactly when enq_vld_o is high.

Reset
REQ-027 SHALL, on rst, set the state to IDLE, the index to 0, enq_vld_o=0 and busy_o=0; req_rdy_o is 1 after reset deasserts.
REQ-028 SHALL abandon a mid-request reset with no beats emitted afterwards; the captured data register needs no reset.
REQ-029 SHALL give rst priority over flush_i and acceptance.

Configuration
REQ-030 SHALL, with SP_FIFO_ENQ_SER_LAST_EN defined, add output enq_last_o (1 bit), high with enq_vld_o exactly for beat len-1.
REQ-031 SHALL, without SP_FIFO_ENQ_SER_LAST_EN, omit enq_last_o and its logic; all other behaviour is identical.

Verification
REQ-032 SHALL test this case: BEATS=8, len=3, data beats 0xA0,0xA1,0xA2, enq_rdy_i=1 -> beats fire on cycles t+1..t+3 in order; req_rdy_o high at t+4; with macro, enq_last_o only with 0xA2.
REQ-033 SHALL test this case: len=4, enq_rdy_i toggles 1,0,0,1,... -> enq_payload_o stays stable while rdy is low; exactly 4 fires, in order.
REQ-034 SHALL test this case: len=0 then len=9 -> first emits nothing and req_rdy_o stays 1; second is clamped to 8 beats.
REQ-035 SHALL test this case: len=8, flush_i high after the 2nd fire -> enq_vld_o low next cycle; exactly 2 beats delivered; a new request is accepted the following cycle.
REQ-036 SHALL test this case: rst high during beat 5 of 8 -> enq_vld_o=0, busy_o=0 next cycle; no further beats.
REQ-037 SHALL test this case: req_vld_i held high with back-to-back len=2 requests -> exactly one idle cycle between the last beat of the first and the first beat of the second.
